// File: rtl/adsr_if.sv
// Envelope generator control/status bundle: register-bank fields in, envelope level out.
interface adsr_if;
  logic       enable;
  logic       gate;
  logic [7:0] attack_rate;
  logic [7:0] decay_rate;
  logic [7:0] sustain_level;
  logic [7:0] release_rate;
  logic [7:0] env_out;
  logic [2:0] env_state;
  logic       env_active;

  modport master (
    output enable, gate, attack_rate, decay_rate, sustain_level, release_rate,
    input  env_out, env_state, env_active
  );

  modport slave (
    input  enable, gate, attack_rate, decay_rate, sustain_level, release_rate,
    output env_out, env_state, env_active
  );
endinterface

// File: rtl/adsr_envelope.sv
// ADSR envelope generator: 16-bit accumulator stepped on a shared prescaler tick,
// envelope level is the accumulator's upper byte.
module adsr_envelope #(
  parameter int PRESCALE = 256
) (
  input  logic   clk,
  input  logic   system_rst_n,
  adsr_if.slave  bus
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t           state;
  logic [15:0]      acc;
  logic [CNT_W-1:0] count;
  logic             active;

  // Rate code 0 still advances by one LSB, so no setting ever freezes the envelope.
  function automatic logic [8:0] rate_step(input logic [7:0] rate);
    return {1'b0, rate} + 9'd1;
  endfunction

  // Attack saturates at full scale instead of wrapping.
  function automatic logic [15:0] sat_attack(input logic [16:0] sum);
    return (sum >= 17'h0FFFF) ? 16'hFFFF : sum[15:0];
  endfunction

  // Decay clamps at the sustain floor; the signed difference catches underflow below zero.
  function automatic logic [15:0] clamp_decay(input logic signed [16:0] diff,
                                              input logic signed [16:0] floor_s);
    return (diff <= floor_s) ? floor_s[15:0] : diff[15:0];
  endfunction

  logic                tick;
  logic [8:0]          atk_step;
  logic [8:0]          dec_step;
  logic [8:0]          rel_step;
  logic [15:0]         floor_lvl;
  logic [16:0]         atk_sum;
  logic signed [16:0]  dec_diff;
  logic signed [16:0]  floor_s;
  logic                atk_full;
  logic                dec_hit;
  logic                rel_done;

  assign tick      = (count == CNT_MAX);
  assign atk_step  = rate_step(bus.attack_rate);
  assign dec_step  = rate_step(bus.decay_rate);
  assign rel_step  = rate_step(bus.release_rate);
  assign floor_lvl = {bus.sustain_level, 8'h00};
  assign atk_sum   = {1'b0, acc} + {8'd0, atk_step};
  assign dec_diff  = $signed({1'b0, acc}) - $signed({8'd0, dec_step});
  assign floor_s   = $signed({1'b0, floor_lvl});
  assign atk_full  = (atk_sum >= 17'h0FFFF);
  assign dec_hit   = (dec_diff <= floor_s);
  assign rel_done  = (acc <= {7'd0, rel_step});

  // Envelope FSM, accumulator and prescaler; gate changes take priority over tick steps.
  always_ff @(posedge clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      state  <= IDLE;
      acc    <= 16'd0;
      count  <= '0;
      active <= 1'b0;
    end else if (!bus.enable) begin
      state  <= IDLE;
      acc    <= 16'd0;
      count  <= '0;
      active <= 1'b0;
    end else begin
      count <= tick ? '0 : count + CNT_W'(1);
      case (state)
        IDLE: begin
          if (bus.gate) begin
            state  <= ATTACK;
            active <= 1'b1;
          end
        end
        ATTACK: begin
          if (!bus.gate) begin
            state <= RELEASE;
          end else if (tick) begin
            acc <= sat_attack(atk_sum);
            if (atk_full) state <= DECAY;
          end
        end
        DECAY: begin
          if (!bus.gate) begin
            state <= RELEASE;
          end else if (tick) begin
            acc <= clamp_decay(dec_diff, floor_s);
            if (dec_hit) state <= SUSTAIN;
          end
        end
        SUSTAIN: begin
          if (!bus.gate) state <= RELEASE;
          else           acc   <= floor_lvl;
        end
        RELEASE: begin
          if (bus.gate) begin
            state <= ATTACK;
          end else if (tick) begin
            if (rel_done) begin
              acc    <= 16'd0;
              state  <= IDLE;
              active <= 1'b0;
            end else begin
              acc <= acc - {7'd0, rel_step};
            end
          end
        end
        default: begin
          state  <= IDLE;
          acc    <= 16'd0;
          active <= 1'b0;
        end
      endcase
    end
  end

  assign bus.env_out    = acc[15:8];
  assign bus.env_state  = state;
  assign bus.env_active = active;

endmodule
